// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the ALU writeback
//   stage and the multiply/divide completion path.
//   - ALU writes always win the port unless a stall is being forced.
//   - Multdiv results that cannot be written immediately are held in a small
//     FIFO and drained whenever the ALU leaves the port idle.
//   - A starvation counter forces a one-cycle ALU stall so that buffered
//     results always drain.
//   - A later ALU write to the same register kills a buffered result (WAW).
//
// Ports
//   clk, clr                   clock, synchronous active-high reset
//   alu_we/alu_rd/alu_data     ALU writeback request
//   alu_stall                  ALU request not taken this cycle, hold it
//   md_valid/md_rd/md_data     multdiv result offer
//   md_ready                   multdiv result taken when md_valid && md_ready
//   rf_we/rf_rd/rf_data        register file write port
module regfile_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        alu_we,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [DEPTH-1:0]         live;
    logic [DEPTH-1:0][4:0]    buf_rd;
    logic [DEPTH-1:0][31:0]   buf_data;
    logic [AW-1:0]            head;
    logic [AW-1:0]            tail;
    logic [CW-1:0]            count;
    logic [SW-1:0]            starve_cnt;

    logic head_live;
    logic alu_go;
    logic md_acc;
    logic push;
    logic pop;

    // md_ready depends only on registered state so the producer never sees
    // a combinational path from its own valid.
    assign md_ready  = (count < CW'(DEPTH));
    assign head_live = (count != '0) && live[head];

    always_comb begin
        alu_stall = 1'b0;
        alu_go    = 1'b0;
        md_acc    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        rf_we     = 1'b0;
        rf_rd     = '0;
        rf_data   = '0;

        if (!clr) begin
            alu_stall = (starve_cnt == SW'(STARVE_MAX)) && head_live;
            // Writes to r0 are architectural no-ops and never claim the port.
            alu_go    = alu_we && (alu_rd != 5'd0) && !alu_stall;
            md_acc    = md_valid && md_ready;

            if (alu_go) begin
                rf_we   = 1'b1;
                rf_rd   = alu_rd;
                rf_data = alu_data;
            end else if (head_live) begin
                rf_we   = 1'b1;
                rf_rd   = buf_rd[head];
                rf_data = buf_data[head];
                pop     = 1'b1;
            end else if ((count == '0) && md_acc && (md_rd != 5'd0)) begin
                // Bypass: empty buffer and a free port, write straight through.
                rf_we   = 1'b1;
                rf_rd   = md_rd;
                rf_data = md_data;
            end

            // A squashed head is thrown away without using the port, so it
            // can retire alongside an ALU write.
            if ((count != '0) && !live[head])
                pop = 1'b1;

            // Enqueue unless dropped (r0), bypassed, or older than a
            // same-cycle ALU write to the same register.
            push = md_acc && (md_rd != 5'd0)
                   && !(alu_go && (md_rd == alu_rd))
                   && !(!alu_go && !head_live && (count == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            live       <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            // WAW squash applies to entries already in the buffer; a push this
            // cycle can never match alu_rd because such pushes are discarded.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_go && (buf_rd[i] == alu_rd))
                    live[i] <= 1'b0;
            end

            if (push) begin
                live[tail]     <= 1'b1;
                buf_rd[tail]   <= md_rd;
                buf_data[tail] <= md_data;
                tail           <= tail + 1'b1;
            end

            if (pop)
                head <= head + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop || (count == '0))
                starve_cnt <= '0;
            else if (head_live && (starve_cnt != SW'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .clr(clr),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        awe;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        stall;
        logic        rdy;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic c, logic awe, logic [4:0] ard, logic [31:0] adat,
                                logic mv, logic [4:0] mrd, logic [31:0] mdat,
                                logic stall, logic rdy, logic we, logic [4:0] rd,
                                logic [31:0] data);
        vec_t v;
        v.clr = c; v.awe = awe; v.ard = ard; v.adat = adat;
        v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.stall = stall; v.rdy = rdy; v.we = we; v.rd = rd; v.data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        clr = v.clr; alu_we = v.awe; alu_rd = v.ard; alu_data = v.adat;
        md_valid = v.mv; md_rd = v.mrd; md_data = v.mdat;
    endtask

    // Scoreboard side: every observed port write must match the oldest
    // expected write.
    task automatic monitor(input string tag);
        wr_t e;
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected write rd"}, {27'd0, rf_rd}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk({tag, " sb rd"}, {27'd0, rf_rd}, {27'd0, e.rd});
                chk({tag, " sb data"}, rf_data, e.data);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        if (v.we) sb.push_back({v.rd, v.data});
        #2;
        chk({tag, " alu_stall"}, {31'd0, alu_stall}, {31'd0, v.stall});
        chk({tag, " md_ready"},  {31'd0, md_ready},  {31'd0, v.rdy});
        chk({tag, " rf_we"},     {31'd0, rf_we},     {31'd0, v.we});
        chk({tag, " rf_rd"},     {27'd0, rf_rd},     {27'd0, v.rd});
        chk({tag, " rf_data"},   rf_data,            v.data);
        monitor(tag);
    endtask

    initial begin
        bit seen;
        // fields: clr awe ard adat mv mrd mdat | stall rdy we rd data
        // reset with an ALU request present
        tbl.push_back(mk(1, 1, 3, 32'h99, 0, 0, 0,            0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 32'h99, 0, 0, 0,            0, 1, 0, 0, 0));
        // bypass, then idle proves nothing was enqueued
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 32'h0000ABCD,      0, 1, 1, 5, 32'h0000ABCD));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 1, 0, 0, 0));
        // buffer two results under continuous ALU traffic, then forced drain
        tbl.push_back(mk(0, 1, 1, 32'h100, 1, 7, 32'h11,      0, 1, 1, 1, 32'h100));
        tbl.push_back(mk(0, 1, 1, 32'h101, 1, 8, 32'h22,      0, 1, 1, 1, 32'h101));
        tbl.push_back(mk(0, 1, 1, 32'h102, 1, 9, 32'h33,      0, 0, 1, 1, 32'h102));
        tbl.push_back(mk(0, 1, 1, 32'h103, 0, 0, 0,           0, 0, 1, 1, 32'h103));
        tbl.push_back(mk(0, 1, 1, 32'h104, 0, 0, 0,           0, 0, 1, 1, 32'h104));
        tbl.push_back(mk(0, 1, 1, 32'h105, 0, 0, 0,           1, 0, 1, 7, 32'h11));
        tbl.push_back(mk(0, 1, 1, 32'h105, 0, 0, 0,           0, 1, 1, 1, 32'h105));
        tbl.push_back(mk(0, 1, 1, 32'h106, 0, 0, 0,           0, 1, 1, 1, 32'h106));
        tbl.push_back(mk(0, 1, 1, 32'h107, 0, 0, 0,           0, 1, 1, 1, 32'h107));
        tbl.push_back(mk(0, 1, 1, 32'h108, 0, 0, 0,           0, 1, 1, 1, 32'h108));
        tbl.push_back(mk(0, 1, 1, 32'h109, 0, 0, 0,           1, 1, 1, 8, 32'h22));
        tbl.push_back(mk(0, 1, 1, 32'h109, 0, 0, 0,           0, 1, 1, 1, 32'h109));
        // WAW squash of a buffered r9
        tbl.push_back(mk(0, 1, 2, 32'h200, 1, 9, 32'h55,      0, 1, 1, 2, 32'h200));
        tbl.push_back(mk(0, 1, 9, 32'h66, 0, 0, 0,            0, 1, 1, 9, 32'h66));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 1, 0, 0, 0));
        // same-cycle conflict on r4
        tbl.push_back(mk(0, 1, 4, 32'h44, 1, 4, 32'h45,       0, 1, 1, 4, 32'h44));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 1, 0, 0, 0));
        // r0 handling
        tbl.push_back(mk(0, 1, 3, 32'h30, 1, 6, 32'h60,       0, 1, 1, 3, 32'h30));
        tbl.push_back(mk(0, 1, 0, 32'hDEAD, 0, 0, 0,          0, 1, 1, 6, 32'h60));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h77,            0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'hBEEF, 1, 10, 32'hAA,    0, 1, 1, 10, 32'hAA));
        // reset flushes a buffered entry
        tbl.push_back(mk(0, 1, 2, 32'h1, 1, 11, 32'hB,        0, 1, 1, 2, 32'h1));
        tbl.push_back(mk(1, 1, 5, 32'h5, 0, 0, 0,             0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 1, 0, 0, 0));

        clr = 1'b1; alu_we = 1'b0; alu_rd = '0; alu_data = '0;
        md_valid = 1'b0; md_rd = '0; md_data = '0;
        @(posedge clk);

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Hand sequence: squash a non-head entry, drain head under forced
        // stall, dead head retires beside an ALU write, then bypass proves
        // the buffer is empty again.
        apply(mk(0, 1, 1, 32'h500, 1, 12, 32'hC1,  0, 1, 1, 1, 32'h500), "seq c0");
        apply(mk(0, 1, 1, 32'h501, 1, 13, 32'hD1,  0, 1, 1, 1, 32'h501), "seq c1");
        apply(mk(0, 1, 13, 32'h777, 0, 0, 0,       0, 0, 1, 13, 32'h777), "seq c2");
        seen = 1'b0;
        for (int k = 3; k < 13 && !seen; k++) begin
            @(negedge clk);
            drive(mk(0, 1, 1, 32'h500 + k, 0, 0, 0, 0, 0, 0, 0, 0));
            #2;
            if (alu_stall === 1'b1) begin
                seen = 1'b1;
                chk("seq stall cycle", k, 5);
                chk("seq drain rd",   {27'd0, rf_rd}, 32'd12);
                chk("seq drain data", rf_data, 32'hC1);
            end else begin
                chk($sformatf("seq c%0d rd", k), {27'd0, rf_rd}, 32'd1);
                chk($sformatf("seq c%0d data", k), rf_data, 32'h500 + k);
            end
        end
        if (!seen) chk("seq stall timeout", 32'd0, 32'd1);
        apply(mk(0, 1, 1, 32'h600, 0, 0, 0,        0, 1, 1, 1, 32'h600), "seq c6");
        apply(mk(0, 0, 0, 0, 1, 14, 32'hE1,       0, 1, 1, 14, 32'hE1), "seq c7");
        apply(mk(0, 0, 0, 0, 0, 0, 0,             0, 1, 0, 0, 0), "seq c8");

        chk("sb drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
